main: RTL and testbench

- Parameterised 8-bit (default) MIPS-style integer ALU for the datapath execute stage.
- Selects one of eight operations with a 6-bit function code (MIPS R-type funct encoding).
- Result and status flags are registered: one clock of latency, asynchronous active-low reset.

---
 rtl/main_if.sv | 24 ++
 rtl/main.sv | 119 +++++++++++
 tb/tb_main.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/main_if.sv
// Operand/result bundle for the execute-stage ALU: the driver supplies Op, A and B,
// and the ALU returns the registered result and status flags.
interface main_if #(
    parameter int bits = 8
);
    logic [5:0]      Op;
    logic [bits-1:0] A;
    logic [bits-1:0] B;
    logic [bits-1:0] out;
    logic            zero;
    logic            carry;
    logic            overflow;
    logic            illegal;

    modport master (
        output Op, A, B,
        input  out, zero, carry, overflow, illegal
    );

    modport slave (
        input  Op, A, B,
        output out, zero, carry, overflow, illegal
    );
endinterface

// File: rtl/main.sv
// MIPS-style integer ALU, R-type funct decode, with one registered stage holding
// the result and the zero/carry/overflow/illegal flags.
module main #(
    parameter int bits = 8
) (
    input logic   clk,
    input logic   rst_n,
    main_if.slave bus
);
    localparam int MSB = bits - 1;

    localparam logic [5:0] OP_ADD = 6'b100000;
    localparam logic [5:0] OP_SUB = 6'b100010;
    localparam logic [5:0] OP_AND = 6'b100100;
    localparam logic [5:0] OP_OR  = 6'b100101;
    localparam logic [5:0] OP_XOR = 6'b100110;
    localparam logic [5:0] OP_NOR = 6'b100111;
    localparam logic [5:0] OP_SRL = 6'b000010;
    localparam logic [5:0] OP_SRA = 6'b000011;

    localparam logic [bits-1:0] SHIFT_LIM = bits[bits-1:0];
    localparam logic [bits:0]   ONE_EXT   = {{bits{1'b0}}, 1'b1};

    // Any amount at or beyond the width leaves only fill bits.
    function automatic logic [bits-1:0] shift_right(
        input logic [bits-1:0] a,
        input logic [bits-1:0] amt,
        input logic            arith
    );
        logic signed [bits-1:0] a_s;
        a_s = a;
        if (amt >= SHIFT_LIM)
            shift_right = arith ? {bits{a[MSB]}} : '0;
        else if (arith)
            shift_right = a_s >>> amt;
        else
            shift_right = a >> amt;
    endfunction

    function automatic logic signed_overflow(
        input logic a_sign,
        input logic b_sign,
        input logic r_sign,
        input logic is_sub
    );
        if (is_sub)
            signed_overflow = (a_sign != b_sign) && (r_sign != a_sign);
        else
            signed_overflow = (a_sign == b_sign) && (r_sign != a_sign);
    endfunction

    logic [bits:0]   sum_ext;
    logic [bits-1:0] res_p0;
    logic            carry_p0;
    logic            ovf_p0;
    logic            ill_p0;
    logic            zero_p0;

    // Stage p0: combinational decode and compute from the current operands.
    always_comb begin
        sum_ext  = '0;
        res_p0   = '0;
        carry_p0 = 1'b0;
        ovf_p0   = 1'b0;
        ill_p0   = 1'b0;
        case (bus.Op)
            OP_ADD: begin
                sum_ext  = {1'b0, bus.A} + {1'b0, bus.B};
                res_p0   = sum_ext[bits-1:0];
                carry_p0 = sum_ext[bits];
                ovf_p0   = signed_overflow(bus.A[MSB], bus.B[MSB], res_p0[MSB], 1'b0);
            end
            OP_SUB: begin
                // carry set means no borrow: A >= B unsigned
                sum_ext  = {1'b0, bus.A} + {1'b0, ~bus.B} + ONE_EXT;
                res_p0   = sum_ext[bits-1:0];
                carry_p0 = sum_ext[bits];
                ovf_p0   = signed_overflow(bus.A[MSB], bus.B[MSB], res_p0[MSB], 1'b1);
            end
            OP_AND:  res_p0 = bus.A & bus.B;
            OP_OR:   res_p0 = bus.A | bus.B;
            OP_XOR:  res_p0 = bus.A ^ bus.B;
            OP_NOR:  res_p0 = ~(bus.A | bus.B);
            OP_SRL:  res_p0 = shift_right(bus.A, bus.B, 1'b0);
            OP_SRA:  res_p0 = shift_right(bus.A, bus.B, 1'b1);
            default: ill_p0 = 1'b1;
        endcase
        zero_p0 = (res_p0 == '0);
    end

    logic [bits-1:0] res_p1;
    logic            zero_p1;
    logic            carry_p1;
    logic            ovf_p1;
    logic            ill_p1;

    // Stage p1: registered outputs; reset clears immediately and reports a zero result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_p1   <= '0;
            zero_p1  <= 1'b1;
            carry_p1 <= 1'b0;
            ovf_p1   <= 1'b0;
            ill_p1   <= 1'b0;
        end else begin
            res_p1   <= res_p0;
            zero_p1  <= zero_p0;
            carry_p1 <= carry_p0;
            ovf_p1   <= ovf_p0;
            ill_p1   <= ill_p0;
        end
    end

    assign bus.out      = res_p1;
    assign bus.zero     = zero_p1;
    assign bus.carry    = carry_p1;
    assign bus.overflow = ovf_p1;
    assign bus.illegal  = ill_p1;
endmodule

// File: tb/tb_main.sv
// Bench for the ALU: directed vectors with literal expectations, plus an
// arithmetic reference model compared against the registered outputs every cycle.
module tb_main;
    localparam int bits = 8;

    typedef struct packed {
        logic [bits-1:0] out;
        logic            zero;
        logic            carry;
        logic            overflow;
        logic            illegal;
    } res_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   errors = 0;
    int   checks = 0;

    main_if #(.bits(bits)) bus ();
    main #(.bits(bits)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    // Reference model in plain integer arithmetic.
    function automatic res_t model(input logic [5:0] op, input logic [bits-1:0] a,
                                   input logic [bits-1:0] b);
        res_t r;
        int ai, bi, sa, sb, m, h, v, s;
        ai = int'(a);
        bi = int'(b);
        m  = 1 << bits;
        h  = 1 << (bits - 1);
        sa = (ai >= h) ? ai - m : ai;
        sb = (bi >= h) ? bi - m : bi;
        r  = '0;
        v  = 0;
        case (op)
            6'b100000: begin
                v = ai + bi;
                r.carry = (v >= m);
                s = sa + sb;
                r.overflow = (s >= h) || (s < -h);
            end
            6'b100010: begin
                v = ai - bi;
                r.carry = (ai >= bi);
                s = sa - sb;
                r.overflow = (s >= h) || (s < -h);
            end
            6'b100100: v = ai & bi;
            6'b100101: v = ai | bi;
            6'b100110: v = ai ^ bi;
            6'b100111: v = ~(ai | bi);
            6'b000010: v = (bi >= bits) ? 0 : (ai >> bi);
            6'b000011: v = (bi >= bits) ? ((sa < 0) ? -1 : 0) : (sa >>> bi);
            default:   r.illegal = 1'b1;
        endcase
        r.out  = v[bits-1:0];
        r.zero = (r.out == '0);
        return r;
    endfunction

    res_t exp_r;
    logic exp_vld = 1'b0;
    res_t got_r;
    assign got_r = '{bus.out, bus.zero, bus.carry, bus.overflow, bus.illegal};

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_vld <= 1'b0;
        end else begin
            exp_vld <= 1'b1;
            exp_r   <= model(bus.Op, bus.A, bus.B);
        end
    end

    always @(negedge clk) begin
        if (!rst_n)
            chk("model_reset", 32'(got_r), 32'(res_t'{'0, 1'b1, 1'b0, 1'b0, 1'b0}));
        else if (exp_vld)
            chk("model", 32'(got_r), 32'(exp_r));
    end

    // flags order: {zero, carry, overflow, illegal}
    task automatic step(input string name, input logic [5:0] op, input logic [7:0] a,
                        input logic [7:0] b, input logic [7:0] want_out, input logic [3:0] want_fl);
        @(negedge clk);
        bus.Op = op;
        bus.A  = a;
        bus.B  = b;
        @(posedge clk);
        #1;
        chk({name, "_out"}, 32'(bus.out), 32'(want_out));
        chk({name, "_flags"}, 32'({bus.zero, bus.carry, bus.overflow, bus.illegal}), 32'(want_fl));
    endtask

    logic [5:0] ops [9] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100110,
                            6'b100111, 6'b000010, 6'b000011, 6'b010101};
    logic [7:0] va  [6] = '{8'h00, 8'hFF, 8'h80, 8'h55, 8'h01, 8'h7F};
    logic [7:0] vb  [6] = '{8'h00, 8'hFF, 8'h7F, 8'hAA, 8'h07, 8'h80};

    initial begin
        bus.Op = 6'd0;
        bus.A  = '0;
        bus.B  = '0;
        #1 rst_n = 1'b0;
        bus.Op = 6'b100000;
        bus.A  = 8'h5A;
        bus.B  = 8'h33;
        #1;
        chk("reset_out", 32'(bus.out), 32'h00);
        chk("reset_flags", 32'({bus.zero, bus.carry, bus.overflow, bus.illegal}), 32'b1000);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        step("add_first", 6'b100000, 8'h90, 8'h01, 8'h91, 4'b0000);
        step("nor",       6'b100111, 8'h90, 8'h01, 8'h6E, 4'b0000);
        step("sub",       6'b100010, 8'h90, 8'h01, 8'h8F, 4'b0100);
        step("and",       6'b100100, 8'h90, 8'h01, 8'h00, 4'b1000);
        step("or",        6'b100101, 8'h90, 8'h01, 8'h91, 4'b0000);
        step("xor",       6'b100110, 8'h90, 8'h01, 8'h91, 4'b0000);
        step("srl",       6'b000010, 8'h90, 8'h01, 8'h48, 4'b0000);
        step("sra",       6'b000011, 8'h90, 8'h01, 8'hC8, 4'b0000);
        step("add_ovf",   6'b100000, 8'h7F, 8'h01, 8'h80, 4'b0010);
        step("add_carry", 6'b100000, 8'hFF, 8'h01, 8'h00, 4'b1100);
        step("sub_borrow",6'b100010, 8'h00, 8'h01, 8'hFF, 4'b0000);
        step("sub_ovf",   6'b100010, 8'h80, 8'h01, 8'h7F, 4'b0110);
        step("srl_b8",    6'b000010, 8'h90, 8'd8,  8'h00, 4'b1000);
        step("sra_b8",    6'b000011, 8'h90, 8'd8,  8'hFF, 4'b0000);
        step("sra_b0",    6'b000011, 8'h90, 8'd0,  8'h90, 4'b0000);
        step("sra_b200",  6'b000011, 8'h70, 8'd200,8'h00, 4'b1000);
        step("illegal",   6'b111111, 8'h90, 8'h01, 8'h00, 4'b1001);
        step("legal_again",6'b100000,8'h90, 8'h01, 8'h91, 4'b0000);

        // Asynchronous reset between edges drops the registered result at once.
        #2 rst_n = 1'b0;
        #1;
        chk("midreset_out", 32'(bus.out), 32'h00);
        chk("midreset_flags", 32'({bus.zero, bus.carry, bus.overflow, bus.illegal}), 32'b1000);
        repeat (2) begin
            @(posedge clk);
            #1;
            chk("held_reset_out", 32'(bus.out), 32'h00);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step("after_reset", 6'b100000, 8'h7F, 8'h01, 8'h80, 4'b0010);

        for (int i = 0; i < 9; i++) begin
            for (int j = 0; j < 6; j++) begin
                @(negedge clk);
                bus.Op = ops[i];
                bus.A  = va[j];
                bus.B  = vb[j];
            end
        end
        @(negedge clk);
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
